// File: rtl/captura_entradas_pkg.sv
// rtl/captura_entradas_pkg.sv - shared types and vector layout for the input-conditioning stage
package pkg_entradas;

    typedef enum logic [1:0] {
        ESTAVEL,
        CONTANDO,
        ATUALIZA
    } est_t;

    localparam int VET_W = 6;

    // Layout of the conditioned vector: {e[1:0], p[3:0]}
    localparam int E_MSB = 5;
    localparam int E_LSB = 4;
    localparam int P_MSB = 3;
    localparam int P_LSB = 0;

endpackage

// File: rtl/captura_entradas_sincronizador.sv
// rtl/captura_entradas_sincronizador.sv - two-flop synchronizer for asynchronous switch levels
module sincronizador #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/captura_entradas.sv
// rtl/captura_entradas.sv - synchronizes and debounces {e,p} as one vector, publishing only settled values
module captura_entradas
    import pkg_entradas::*;
#(
    parameter int DEB_CICLOS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] e_raw,
    input  logic [3:0] p_raw,
    output logic [1:0] e,
    output logic [3:0] p,
    output logic       mudou,
    output logic       estavel
);

    localparam int CNT_W = $clog2(DEB_CICLOS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CICLOS - 1);

    logic [VET_W-1:0] s2;
    logic [VET_W-1:0] candidate;
    logic [VET_W-1:0] vet_pub;
    logic [CNT_W-1:0] cnt;
    est_t             state;

    sincronizador #(.W(VET_W)) u_sinc (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({e_raw, p_raw}),
        .q     (s2)
    );

    assign e = vet_pub[E_MSB:E_LSB];
    assign p = vet_pub[P_MSB:P_LSB];

    // The whole vector is debounced together so downstream never sees a mix of old and new bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ESTAVEL;
            candidate <= '0;
            vet_pub   <= '0;
            cnt       <= '0;
            mudou     <= 1'b0;
            estavel   <= 1'b1;
        end else begin
            mudou <= 1'b0;
            case (state)
                ESTAVEL: begin
                    if (s2 != vet_pub) begin
                        candidate <= s2;
                        cnt       <= '0;
                        state     <= CONTANDO;
                        estavel   <= 1'b0;
                    end
                end
                CONTANDO: begin
                    if (s2 == vet_pub) begin
                        state   <= ESTAVEL;
                        estavel <= 1'b1;
                    end else if (s2 != candidate) begin
                        candidate <= s2;
                        cnt       <= '0;
                    end else if (cnt == CNT_MAX) begin
                        vet_pub <= candidate;
                        state   <= ATUALIZA;
                        mudou   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ATUALIZA: begin
                    state   <= ESTAVEL;
                    estavel <= 1'b1;
                end
                default: begin
                    state   <= ESTAVEL;
                    estavel <= 1'b1;
                end
            endcase
        end
    end

endmodule
